// File: rtl/shift_rows_pipe_if.sv
// rtl/shift_rows_pipe_if.sv - handshake bundle for the shift_rows_pipe stage
//
// Purpose: groups the upstream (in_*) and downstream (out_*) handshake and
// payload signals of one shift_rows_pipe instance.
// Modports:
//   master - the surrounding pipeline: drives in_* beats and out_ready,
//            observes in_ready and the out_* beat.
//   slave  - the stage itself: the mirror image of master.
// Parameters: NB (state columns, data is 32*NB bits), TAG_W (sideband tag width).

interface shift_rows_pipe_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [32*NB-1:0]  in_data;
  logic [3:0]        in_round;
  logic              in_inv;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [32*NB-1:0]  out_data;
  logic [3:0]        out_round;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_data, in_round, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_round, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_round, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_round, out_tag
  );
endinterface

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - registered, handshaked Rijndael ShiftRows/InvShiftRows stage
//
// Purpose: applies the Rijndael row rotation (NB = 4, 6 or 8 columns) to each
// accepted beat and buffers it in a two-entry main/skid buffer so the round
// pipeline can stall without a combinational ready path.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - shift_rows_pipe_if.slave: in_valid/in_ready/in_data/in_round/
//           in_inv/in_tag upstream, out_valid/out_ready/out_data/out_round/
//           out_tag downstream
// Build option: define SHIFT_ROWS_INV_EN to build the inverse path selected by
// in_inv; without it the stage is encrypt-only and in_inv is ignored.

module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int NR    = 10,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_rows_pipe_if.slave    bus
);

  localparam int W = 32 * NB;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Byte k of the state is column k/4, row k%4. Row offsets are static, so
  // both directions are pure wiring.
  logic [W-1:0] fwd_data;
  logic [W-1:0] xform_data;
  logic         bypass;

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
      localparam int SRC_F = (c + OFF) % NB;
      assign fwd_data[8*(4*c+r) +: 8] = bus.in_data[8*(4*SRC_F+r) +: 8];
    end
  end

  // Rounds outside 1..NR carry the state through untouched.
  assign bypass = (bus.in_round == 4'd0) || ({28'd0, bus.in_round} > NR);

`ifdef SHIFT_ROWS_INV_EN
  logic [W-1:0] inv_data;

  for (genvar c = 0; c < NB; c++) begin : g_icol
    for (genvar r = 0; r < 4; r++) begin : g_irow
      localparam int OFF = (NB == 8 && r >= 2) ? r + 1 : r;
      // Adding NB before the modulo keeps the source column non-negative.
      localparam int SRC_I = (c + NB - OFF) % NB;
      assign inv_data[8*(4*c+r) +: 8] = bus.in_data[8*(4*SRC_I+r) +: 8];
    end
  end

  assign xform_data = bypass ? bus.in_data : (bus.in_inv ? inv_data : fwd_data);
`else
  logic unused_inv;
  assign unused_inv = bus.in_inv;
  assign xform_data = bypass ? bus.in_data : fwd_data;
`endif

  // Occupancy FSM: EMPTY, ONE (M valid), FULL (M and S valid).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       m_data_q, m_data_d, s_data_q, s_data_d;
  logic [3:0]         m_round_q, m_round_d, s_round_q, s_round_d;
  logic [TAG_W-1:0]   m_tag_q, m_tag_d, s_tag_q, s_tag_d;
  logic               accept;
  logic               drain;

  // Ready depends on state only, so out_ready never reaches in_ready.
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign accept        = bus.in_valid && bus.in_ready;
  assign drain         = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    m_data_d  = m_data_q;
    m_round_d = m_round_q;
    m_tag_d   = m_tag_q;
    s_data_d  = s_data_q;
    s_round_d = s_round_q;
    s_tag_d   = s_tag_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          m_data_d  = xform_data;
          m_round_d = bus.in_round;
          m_tag_d   = bus.in_tag;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          // M leaves this edge, so the new beat replaces it directly.
          m_data_d  = xform_data;
          m_round_d = bus.in_round;
          m_tag_d   = bus.in_tag;
        end else if (accept) begin
          s_data_d  = xform_data;
          s_round_d = bus.in_round;
          s_tag_d   = bus.in_tag;
          state_d   = FULL;
        end else if (drain) begin
          state_d   = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          m_data_d  = s_data_q;
          m_round_d = s_round_q;
          m_tag_d   = s_tag_q;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      m_data_q  <= '0;
      m_round_q <= '0;
      m_tag_q   <= '0;
      s_data_q  <= '0;
      s_round_q <= '0;
      s_tag_q   <= '0;
    end else begin
      state_q   <= state_d;
      m_data_q  <= m_data_d;
      m_round_q <= m_round_d;
      m_tag_q   <= m_tag_d;
      s_data_q  <= s_data_d;
      s_round_q <= s_round_d;
      s_tag_q   <= s_tag_d;
    end
  end

  assign bus.out_data  = m_data_q;
  assign bus.out_round = m_round_q;
  assign bus.out_tag   = m_tag_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - scoreboard bench for shift_rows_pipe (NB=4 and NB=8 instances)

module tb_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef SHIFT_ROWS_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  shift_rows_pipe_if #(.NB(4), .TAG_W(4)) b4 ();
  shift_rows_pipe_if #(.NB(8), .TAG_W(4)) b8 ();

  shift_rows_pipe #(.NB(4), .NR(10), .TAG_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  shift_rows_pipe #(.NB(8), .NR(14), .TAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    logic [255:0] data;
    logic [3:0]   round;
    logic [3:0]   tag;
  } beat_t;

  beat_t q4[$];
  beat_t q8[$];
  int checks = 0;
  int errors = 0;

  // State as a 4 x NB byte matrix; rotate each row by its offset.
  function automatic logic [255:0] ref_xform(input logic [255:0] d, input int nb,
                                             input int nr, input int rnd, input bit inv);
    logic [7:0]   st [4][8];
    logic [255:0] o;
    int           off [4];
    int           src;
    bit           do_inv;
    if (rnd == 0 || rnd > nr) return d;
    do_inv = INV_EN && inv;
    off[0] = 0;
    off[1] = 1;
    off[2] = (nb == 8) ? 3 : 2;
    off[3] = (nb == 8) ? 4 : 3;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = d[8*(4*c+r) +: 8];
    o = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        src = do_inv ? (((c - off[r]) % nb) + nb) % nb : (c + off[r]) % nb;
        o[8*(4*c+r) +: 8] = st[r][src];
      end
    return o;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step4(input bit v, input logic [127:0] d, input logic [3:0] rnd,
                       input bit inv, input logic [3:0] tag, input bit ordy,
                       input bit fixed, input logic [127:0] exp_d, output bit acc);
    beat_t e;
    @(negedge clk);
    b4.in_valid  = v;
    b4.in_data   = d;
    b4.in_round  = rnd;
    b4.in_inv    = inv;
    b4.in_tag    = tag;
    b4.out_ready = ordy;
    acc = v && b4.in_ready && rst_n;
    if (acc) begin
      e.data  = fixed ? {128'd0, exp_d} : ref_xform({128'd0, d}, 4, 10, int'(rnd), inv);
      e.round = rnd;
      e.tag   = tag;
      q4.push_back(e);
    end
  endtask

  task automatic step4r(input bit v, input logic [3:0] tag, input bit ordy, output bit acc);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    step4(v, d, 4'($urandom_range(0, 15)), 1'($urandom), tag, ordy, 1'b0, '0, acc);
  endtask

  task automatic step8(input bit v, input logic [255:0] d, input logic [3:0] rnd,
                       input bit inv, input logic [3:0] tag, input bit ordy);
    beat_t e;
    @(negedge clk);
    b8.in_valid  = v;
    b8.in_data   = d;
    b8.in_round  = rnd;
    b8.in_inv    = inv;
    b8.in_tag    = tag;
    b8.out_ready = ordy;
    if (v && b8.in_ready && rst_n) begin
      e.data  = ref_xform(d, 8, 14, int'(rnd), inv);
      e.round = rnd;
      e.tag   = tag;
      q8.push_back(e);
    end
  endtask

  task automatic drain4(input string name);
    bit acc;
    for (int i = 0; i < 40 && q4.size() != 0; i++)
      step4(1'b0, '0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, '0, acc);
    chk(name, 256'(q4.size()), 256'd0);
  endtask

  // Monitor for the NB=4 instance: pops on every transfer, checks hold while stalled.
  initial begin : mon4
    logic [127:0] pd;
    logic [3:0]   pr;
    logic [3:0]   pt;
    bit           pstall;
    beat_t        e;
    pstall = 1'b0;
    pd = '0;
    pr = '0;
    pt = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && b4.out_valid) begin
        if (pstall) begin
          chk("hold4_data", {128'd0, b4.out_data}, {128'd0, pd});
          chk("hold4_round", 256'(b4.out_round), 256'(pr));
          chk("hold4_tag", 256'(b4.out_tag), 256'(pt));
        end
        if (b4.out_ready) begin
          if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out4_unexpected: got beat tag %0d expected none", b4.out_tag);
          end else begin
            e = q4.pop_front();
            chk("out4_data", {128'd0, b4.out_data}, e.data);
            chk("out4_round", 256'(b4.out_round), 256'(e.round));
            chk("out4_tag", 256'(b4.out_tag), 256'(e.tag));
          end
        end
        pstall = !b4.out_ready;
        pd = b4.out_data;
        pr = b4.out_round;
        pt = b4.out_tag;
      end else begin
        pstall = 1'b0;
      end
    end
  end

  initial begin : mon8
    beat_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out8_unexpected: got beat tag %0d expected none", b8.out_tag);
        end else begin
          e = q8.pop_front();
          chk("out8_data", b8.out_data, e.data);
          chk("out8_round", 256'(b8.out_round), 256'(e.round));
          chk("out8_tag", 256'(b8.out_tag), 256'(e.tag));
        end
      end
    end
  end

  initial begin : main
    logic [127:0] v_in;
    logic [127:0] v_out;
    logic [255:0] d8;
    bit           acc;
    int           tag;
    int           cyc;

    v_in  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
    v_out = 128'he598271ef11141b8ae52b4e0305dbfd4;

    b4.in_valid = 1'b0; b4.in_data = '0; b4.in_round = '0; b4.in_inv = 1'b0;
    b4.in_tag = '0; b4.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.in_round = '0; b8.in_inv = 1'b0;
    b8.in_tag = '0; b8.out_ready = 1'b0;

    #2;
    chk("rst_out_valid", 256'(b4.out_valid), 256'd0);
    chk("rst_in_ready", 256'(b4.in_ready), 256'd1);
    chk("rst_out_data", {128'd0, b4.out_data}, 256'd0);
    chk("rst_out_round", 256'(b4.out_round), 256'd0);
    chk("rst_out_tag", 256'(b4.out_tag), 256'd0);
    chk("rst8_out_valid", 256'(b8.out_valid), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known-answer vectors and 1-cycle latency from EMPTY.
    step4(1'b1, v_in, 4'd1, 1'b0, 4'd1, 1'b1, 1'b1, v_out, acc);
    step4(1'b1, v_out, 4'd1, 1'b1, 4'd2, 1'b1, INV_EN, v_in, acc);
    #2 chk("latency1", 256'(b4.out_valid), 256'd1);
    step4(1'b1, v_in, 4'd0, 1'b1, 4'd3, 1'b1, 1'b1, v_in, acc);
    step4(1'b1, v_in, 4'd11, 1'b0, 4'd4, 1'b1, 1'b1, v_in, acc);
    step4(1'b1, v_out, 4'd11, 1'b1, 4'd5, 1'b1, 1'b1, v_out, acc);
    step4(1'b1, v_in, 4'd10, 1'b0, 4'd6, 1'b1, 1'b0, '0, acc);
    drain4("drain_kat");

    // Backpressure: out_ready low for the first 3 cycles.
    tag = 0;
    for (cyc = 0; cyc < 30 && tag < 10; cyc++) begin
      step4r(1'b1, 4'(tag), cyc >= 3, acc);
      chk("bp_in_ready", 256'(b4.in_ready), 256'(cyc < 2 || cyc >= 4));
      if (acc) tag++;
    end
    chk("bp_all_sent", 256'(tag), 256'd10);
    drain4("drain_bp");

    // Accept and drain together while in ONE.
    step4r(1'b1, 4'd0, 1'b1, acc);
    for (int i = 1; i <= 8; i++) begin
      step4r(1'b1, 4'(i), 1'b1, acc);
      chk("ad_in_ready", 256'(b4.in_ready), 256'd1);
      chk("ad_out_valid", 256'(b4.out_valid), 256'd1);
    end
    drain4("drain_ad");

    // Random traffic with random stalls.
    for (int i = 0; i < 400; i++)
      step4r($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 9) < 7, acc);
    drain4("drain_rand");

    // NB=8 instance: byte k = k, then random traffic.
    for (int k = 0; k < 32; k++) d8[8*k +: 8] = 8'(k);
    step8(1'b1, d8, 4'd1, 1'b0, 4'd1, 1'b1);
    for (int i = 0; i < 60; i++)
      step8($urandom_range(0, 3) != 0,
            {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
            4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 40 && q8.size() != 0; i++)
      step8(1'b0, '0, 4'd0, 1'b0, 4'd0, 1'b1);
    chk("drain8", 256'(q8.size()), 256'd0);
    step8(1'b0, '0, 4'd0, 1'b0, 4'd0, 1'b0);

    // Reset while FULL, then one beat after release.
    step4r(1'b1, 4'd7, 1'b0, acc);
    step4r(1'b1, 4'd8, 1'b0, acc);
    step4(1'b0, '0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, '0, acc);
    chk("full_in_ready", 256'(b4.in_ready), 256'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 256'(b4.out_valid), 256'd0);
    chk("arst_in_ready", 256'(b4.in_ready), 256'd1);
    chk("arst_out_data", {128'd0, b4.out_data}, 256'd0);
    chk("arst_out_tag", 256'(b4.out_tag), 256'd0);
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step4r(1'b1, 4'd9, 1'b1, acc);
    chk("post_rst_acc", 256'(acc), 256'd1);
    step4(1'b0, '0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, '0, acc);
    #2 chk("post_rst_latency", 256'(b4.out_valid), 256'd1);
    drain4("drain_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
